// File: rtl/pll_dyn_cfg_ctrl_if.sv
// Reconfiguration request handshake between a requester and pll_dyn_cfg_ctrl.
// The requester holds cfg_req with stable fields until it sees the one-cycle cfg_ack.
interface pll_dyn_cfg_ctrl_if;
    logic        cfg_req;
    logic [9:0]  cfg_odiv;
    logic [9:0]  cfg_duty;
    logic [12:0] cfg_phase;
    logic        cfg_ack;

    modport master (output cfg_req, cfg_odiv, cfg_duty, cfg_phase, input cfg_ack);
    modport slave  (input cfg_req, cfg_odiv, cfg_duty, cfg_phase, output cfg_ack);
endinterface

// File: rtl/pll_dyn_cfg_ctrl.sv
// PLL dynamic reconfiguration controller: range-checks requests, sequences pll_rst,
// waits for a stable synchronised lock with timeout, and flags lock loss while idle.
module pll_dyn_cfg_ctrl #(
    parameter int          RST_CYCLES   = 16,
    parameter int          LOCK_STABLE  = 8,
    parameter int          LOCK_TIMEOUT = 65535,
    parameter logic [9:0]  ODIV_INIT    = 10'd100,
    parameter logic [9:0]  DUTY_INIT    = 10'd100,
    parameter logic [12:0] PHASE_INIT   = 13'd16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    pll_dyn_cfg_ctrl_if.slave        cfg,
    input  logic                     i_pll_lock,
    output logic                     o_pll_rst,
    output logic [9:0]               o_dyn_odiv,
    output logic [9:0]               o_dyn_duty,
    output logic [12:0]              o_dyn_phase,
    output logic                     o_busy,
    output logic                     o_locked,
    output logic                     o_cfg_done,
    output logic                     o_cfg_err,
    output logic                     o_lock_lost
);
    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(LOCK_STABLE) + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_ASSERT_RST, ST_WAIT_LOCK, ST_STABLE} state_t;

    state_t        r_state;
    logic [RW-1:0] r_rst_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [SW-1:0] r_stb_cnt;
    logic          r_lock_m, r_lock_s;
    logic [9:0]    r_sh_odiv, r_sh_duty, r_dyn_odiv, r_dyn_duty;
    logic [12:0]   r_sh_phase, r_dyn_phase;
    logic          r_pll_rst, r_busy, r_locked, r_ack, r_done, r_err, r_lost;
    logic          w_req_ok, w_to_hit, w_stb_last;
    logic [TW-1:0] w_to_nxt;

    function automatic logic [TW-1:0] to_sat_inc(input logic [TW-1:0] v);
        return (v >= TW'(LOCK_TIMEOUT)) ? v : v + TW'(1);
    endfunction

    // duty is compared against 2*odiv in 11 bits so a large divider cannot overflow
    assign w_req_ok   = (r_sh_odiv >= 10'd2) && (r_sh_duty != 10'd0) &&
                        ({1'b0, r_sh_duty} < {r_sh_odiv, 1'b0});
    assign w_to_nxt   = to_sat_inc(r_to_cnt);
    assign w_to_hit   = (r_to_cnt >= TW'(LOCK_TIMEOUT - 1));
    assign w_stb_last = (r_stb_cnt >= SW'(LOCK_STABLE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= i_pll_lock;
            r_lock_s <= r_lock_m;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_ASSERT_RST;
            r_rst_cnt   <= '0;
            r_to_cnt    <= '0;
            r_stb_cnt   <= '0;
            r_sh_odiv   <= '0;
            r_sh_duty   <= '0;
            r_sh_phase  <= '0;
            r_dyn_odiv  <= ODIV_INIT;
            r_dyn_duty  <= DUTY_INIT;
            r_dyn_phase <= PHASE_INIT;
            r_pll_rst   <= 1'b1;
            r_busy      <= 1'b1;
            r_locked    <= 1'b0;
            r_ack       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_lost <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // lock loss outranks a request; the request stays pending un-acked
                    if (r_locked && !r_lock_s) begin
                        r_lost   <= 1'b1;
                        r_locked <= 1'b0;
                        r_to_cnt <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_WAIT_LOCK;
                    end else if (cfg.cfg_req) begin
                        r_sh_odiv  <= cfg.cfg_odiv;
                        r_sh_duty  <= cfg.cfg_duty;
                        r_sh_phase <= cfg.cfg_phase;
                        r_ack      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_req_ok) begin
                        r_dyn_odiv  <= r_sh_odiv;
                        r_dyn_duty  <= r_sh_duty;
                        r_dyn_phase <= r_sh_phase;
                        r_pll_rst   <= 1'b1;
                        r_locked    <= 1'b0;
                        r_rst_cnt   <= '0;
                        r_state     <= ST_ASSERT_RST;
                    end else begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ASSERT_RST: begin
                    if (r_rst_cnt >= RW'(RST_CYCLES - 1)) begin
                        r_pll_rst <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= ST_WAIT_LOCK;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    r_to_cnt <= w_to_nxt;
                    if (r_lock_s && (LOCK_STABLE == 1)) begin
                        r_locked <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (w_to_hit) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (r_lock_s) begin
                        r_stb_cnt <= SW'(1);
                        r_state   <= ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    // timeout keeps running from pll_rst release; completion wins a tie
                    r_to_cnt <= w_to_nxt;
                    if (r_lock_s && w_stb_last) begin
                        r_locked <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (w_to_hit) begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (r_lock_s) begin
                        r_stb_cnt <= r_stb_cnt + SW'(1);
                    end else begin
                        r_state <= ST_WAIT_LOCK;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_ack  = r_ack;
    assign o_pll_rst    = r_pll_rst;
    assign o_dyn_odiv   = r_dyn_odiv;
    assign o_dyn_duty   = r_dyn_duty;
    assign o_dyn_phase  = r_dyn_phase;
    assign o_busy       = r_busy;
    assign o_locked     = r_locked;
    assign o_cfg_done   = r_done;
    assign o_cfg_err    = r_err;
    assign o_lock_lost  = r_lost;
endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Scoreboard bench for pll_dyn_cfg_ctrl with a behavioural PLL lock model.
// Expected handshake/status events are queued with each stimulus and popped as the DUT pulses.
module tb_pll_dyn_cfg_ctrl;
    localparam int RST_C    = 4;
    localparam int STB_C    = 3;
    localparam int TO_C     = 50;
    localparam int LOCK_DLY = 10;
    localparam int EV_ACK = 1, EV_DONE = 2, EV_ERR = 3, EV_LOST = 4;

    typedef struct {
        int          kind;
        logic [9:0]  odiv;
        logic [9:0]  duty;
        logic [12:0] phase;
        logic        locked;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_lock = 1'b0;
    logic        pll_rst, busy, locked, done, err, lost;
    logic [9:0]  dyn_odiv, dyn_duty;
    logic [12:0] dyn_phase;

    pll_dyn_cfg_ctrl_if u_if ();

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES  (RST_C),
        .LOCK_STABLE (STB_C),
        .LOCK_TIMEOUT(TO_C)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .cfg        (u_if),
        .i_pll_lock (pll_lock),
        .o_pll_rst  (pll_rst),
        .o_dyn_odiv (dyn_odiv),
        .o_dyn_duty (dyn_duty),
        .o_dyn_phase(dyn_phase),
        .o_busy     (busy),
        .o_locked   (locked),
        .o_cfg_done (done),
        .o_cfg_err  (err),
        .o_lock_lost(lost)
    );

    always #5 clk = ~clk;

    ev_t sb_q[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    // PLL model state: pcnt counts cycles since pll_rst release, cyc is free-running
    int  cyc = 0, pcnt = 0;
    bit  hold0 = 1'b0;
    int  g_start = 0, g_len = 0, d_start = 0, d_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [9:0] o, input logic [9:0] d,
                        input logic [12:0] p, input logic l);
        ev_t e;
        e.kind = k; e.odiv = o; e.duty = d; e.phase = p; e.locked = l;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k);
        ev_t e;
        if (sb_q.size() == 0) begin
            chk("sb_unexpected_event", k, 0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_kind", k, e.kind);
            chk("sb_odiv", dyn_odiv, e.odiv);
            chk("sb_duty", dyn_duty, e.duty);
            chk("sb_phase", dyn_phase, e.phase);
            chk("sb_locked", locked, e.locked);
        end
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (pll_rst) pcnt = 0;
        else         pcnt++;
        pll_lock = !pll_rst && (pcnt >= LOCK_DLY) && !hold0 &&
                   !(pcnt >= g_start && pcnt < g_start + g_len) &&
                   !(cyc >= d_start && cyc < d_start + d_len);
    end

    initial forever begin
        @(negedge clk);
        if ({u_if.cfg_ack, done, err, lost} != 4'b0000) begin
            chk("one_pulse", $countones({u_if.cfg_ack, done, err, lost}), 1);
            if (lost)         pop_cmp(EV_LOST);
            if (u_if.cfg_ack) pop_cmp(EV_ACK);
            if (done)         pop_cmp(EV_DONE);
            if (err)          pop_cmp(EV_ERR);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rst_low(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 200) begin step(); n++; end
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!(done || err) && n < 200) begin step(); n++; end
    endtask

    task automatic do_req(input logic [9:0] o, input logic [9:0] d, input logic [12:0] p,
                          output int lat);
        u_if.cfg_req   = 1'b1;
        u_if.cfg_odiv  = o;
        u_if.cfg_duty  = d;
        u_if.cfg_phase = p;
        lat = 0;
        do begin step(); lat++; end while (!u_if.cfg_ack && lat < 100);
        u_if.cfg_req = 1'b0;
    endtask

    logic [9:0] inv_o [3];
    logic [9:0] inv_d [3];

    initial begin
        int n, lat;
        logic rst_seen;
        inv_o = '{10'd1, 10'd10, 10'd10};
        inv_d = '{10'd1, 10'd20, 10'd0};
        u_if.cfg_req = 1'b0; u_if.cfg_odiv = '0; u_if.cfg_duty = '0; u_if.cfg_phase = '0;
        repeat (3) step();

        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 1);
        chk("rst_odiv", dyn_odiv, 100);
        chk("rst_duty", dyn_duty, 100);
        chk("rst_phase", dyn_phase, 16);
        chk("rst_pulses", {u_if.cfg_ack, done, err, lost}, 0);

        // power-on: lock reaches the FSM 2 cycles after it is sampled, then 3 lock_s cycles
        push(EV_DONE, 100, 100, 16, 1);
        rst_n = 1'b1;
        wait_rst_low(n);  chk("po_rst_cycles", n, RST_C);
        wait_end(n);      chk("po_done_lat", n, 14);
        chk("po_locked", locked, 1);
        chk("po_busy", busy, 0);
        step();
        chk("po_done_1cyc", done, 0);

        push(EV_ACK, 100, 100, 16, 1);
        push(EV_DONE, 200, 200, 16, 1);
        do_req(200, 200, 16, lat);  chk("t2_ack_lat", lat, 1);
        step();
        chk("t2_odiv", dyn_odiv, 200);
        chk("t2_duty", dyn_duty, 200);
        chk("t2_pll_rst", pll_rst, 1);
        chk("t2_locked", locked, 0);
        wait_rst_low(n);  chk("t2_rst_cycles", n, RST_C);
        wait_end(n);      chk("t2_done_lat", n, 14);
        step();

        for (int i = 0; i < 3; i++) begin
            push(EV_ACK, 200, 200, 16, 1);
            push(EV_ERR, 200, 200, 16, 1);
            do_req(inv_o[i], inv_d[i], 13'd5, lat);
            chk("t3_ack_lat", lat, 1);
            chk("t3_pll_rst_ack", pll_rst, 0);
            step();
            chk("t3_err", err, 1);
            chk("t3_pll_rst_err", pll_rst, 0);
            step();
        end
        chk("t3_odiv_kept", dyn_odiv, 200);
        chk("t3_locked_kept", locked, 1);

        hold0 = 1'b1;
        push(EV_ACK, 200, 200, 16, 1);
        push(EV_ERR, 50, 60, 7, 0);
        do_req(50, 60, 7, lat);
        step();
        wait_rst_low(n);  chk("t4_rst_cycles", n, RST_C);
        wait_end(n);      chk("t4_timeout_lat", n, TO_C);
        chk("t4_err", err, 1);
        chk("t4_locked", locked, 0);
        chk("t4_busy", busy, 0);
        hold0 = 1'b0;
        repeat (15) step();
        chk("t4_untracked_locked", locked, 0);
        chk("t4_untracked_busy", busy, 0);
        push(EV_ACK, 50, 60, 7, 0);
        push(EV_DONE, 200, 200, 16, 1);
        do_req(200, 200, 16, lat);
        step();
        wait_rst_low(n);
        wait_end(n);
        chk("t4_recover_done", done, 1);
        step();

        // lock dips for 3 samples after 2 good ones: stable count restarts
        g_start = 12; g_len = 3;
        push(EV_ACK, 200, 200, 16, 1);
        push(EV_DONE, 120, 100, 3, 1);
        do_req(120, 100, 3, lat);
        step();
        wait_rst_low(n);
        wait_end(n);      chk("t5_glitch_done_lat", n, 19);
        g_len = 0;
        step();

        push(EV_LOST, 120, 100, 3, 0);
        push(EV_DONE, 120, 100, 3, 1);
        d_start = cyc + 2; d_len = 5;
        n = 0; rst_seen = 1'b0;
        while (!done && n < 100) begin step(); n++; rst_seen |= pll_rst; end
        chk("t5_loss_recover_done", done, 1);
        chk("t5_loss_no_pll_rst", rst_seen, 0);
        step();

        push(EV_ACK, 120, 100, 3, 1);
        do_req(80, 100, 9, lat);
        step();
        wait_rst_low(n);
        repeat (3) step();
        chk("t6_busy_wait", busy, 1);
        rst_n = 1'b0;
        step();
        chk("t6_rst_odiv", dyn_odiv, 100);
        chk("t6_rst_duty", dyn_duty, 100);
        chk("t6_rst_phase", dyn_phase, 16);
        chk("t6_rst_pll_rst", pll_rst, 1);
        chk("t6_rst_locked", locked, 0);
        sb_q.delete();
        push(EV_DONE, 100, 100, 16, 1);
        rst_n = 1'b1;
        wait_rst_low(n);  chk("t6_po_rst_cycles", n, RST_C);
        wait_end(n);      chk("t6_po_done_lat", n, 14);
        step();

        // request lands in the same cycle the FSM sees lock_s fall
        push(EV_LOST, 100, 100, 16, 0);
        push(EV_DONE, 100, 100, 16, 1);
        push(EV_ACK, 100, 100, 16, 1);
        push(EV_DONE, 64, 100, 2, 1);
        d_start = cyc + 2; d_len = 5;
        repeat (4) step();
        u_if.cfg_req = 1'b1; u_if.cfg_odiv = 10'd64; u_if.cfg_duty = 10'd100; u_if.cfg_phase = 13'd2;
        step();
        chk("t6_coll_lost", lost, 1);
        chk("t6_coll_no_ack", u_if.cfg_ack, 0);
        n = 0;
        while (!u_if.cfg_ack && n < 100) begin step(); n++; end
        u_if.cfg_req = 1'b0;
        chk("t6_coll_ack", u_if.cfg_ack, 1);
        chk("t6_coll_ack_locked", locked, 1);
        step();
        wait_rst_low(n);
        wait_end(n);
        chk("t6_coll_done", done, 1);
        repeat (3) step();

        chk("sb_left", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
